// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequencing controller for an Sv39 TLB array.
// Qualifies hits and permissions, walks the three-level page table over a
// single memory port on a miss, picks a victim and fills it, writes back
// A|D on the first store to a clean page, and sequences full flushes.
module tlb_ctrl #(
   parameter int ENTRIES = 8,
   parameter int IW      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read,
   input  logic                  write,
   input  logic                  execute,
   input  logic [63:0]           addr_va,
   input  logic [43:0]           satp_ppn,
   input  logic                  flush,
   input  logic [ENTRIES-1:0]    hit_vec,
   input  logic [ENTRIES-1:0]    valid_vec,
   input  logic [12*ENTRIES-1:0] acc_count_flat,
   input  logic [63:0]           hit_pte,
   input  logic [63:0]           hit_pte_pa,
   input  logic [43:0]           hit_ppn,
   output logic [ENTRIES-1:0]    tlb_write,
   output logic                  tlb_clear,
   output logic [ENTRIES-1:0]    tlb_d_set,
   output logic [26:0]           vpn_fill,
   output logic [43:0]           ppn_fill,
   output logic [63:0]           pte_fill,
   output logic [63:0]           pte_pa_fill,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [63:0]           mem_addr,
   output logic [63:0]           mem_wdata,
   input  logic                  mem_rdy,
   input  logic [63:0]           mem_rdata,
   output logic                  trans_rdy,
   output logic [55:0]           pa_out,
   output logic                  load_pf,
   output logic                  store_pf,
   output logic                  ins_pf
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WALK_RD  = 3'd1,
      WALK_CHK = 3'd2,
      FILL     = 3'd3,
      DWB      = 3'd4,
      DSET     = 3'd5,
      FLUSH    = 3'd6
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [1:0]       level_r;
   logic [55:0]      a_r;
   logic [26:0]      vpn_r;
   logic [63:0]      pte_r;
   logic [63:0]      pte_addr_r;
   logic             rd_r;
   logic             wr_r;
   logic             ex_r;
   logic [IW-1:0]    hit_idx_r;
   logic [63:0]      dwb_addr_r;
   logic [63:0]      dwb_data_r;

   logic             req_s;
   logic             hit_s;
   logic             perm_ok_s;
   logic [IW-1:0]    hit_idx_s;
   logic [IW-1:0]    victim_s;
   logic [8:0]       vpn_lvl_s;
   logic [63:0]      walk_addr_s;
   logic [43:0]      leaf_ppn_s;
   logic             bad_pte_s;
   logic             non_leaf_s;
   logic             misalign_s;
   logic             walk_fault_s;
   logic             start_walk_s;
   logic             start_dwb_s;
   logic             descend_s;

   // Bits above the Sv39 VA width take no part in translation.
   logic             unused_s;
   assign unused_s = ^addr_va[63:39];

   function automatic logic [ENTRIES-1:0] onehot_f(input logic [IW-1:0] idx);
      logic [ENTRIES-1:0] vec;
      vec      = {ENTRIES{1'b0}};
      vec[idx] = 1'b1;
      return vec;
   endfunction

   // Request decode: hit qualification, permission check, hit index.
   always_comb begin
      req_s     = read | write | execute;
      hit_s     = |hit_vec;
      perm_ok_s = (read & hit_pte[1]) | (write & hit_pte[2]) | (execute & hit_pte[3]);
      hit_idx_s = {IW{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_idx_s = IW'(i);
         end else begin
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // Victim choice: lowest invalid entry, else lowest-index minimum acc_count.
   always_comb begin
      logic [IW-1:0] inv_idx;
      logic          inv_found;
      logic [IW-1:0] min_idx;
      logic [11:0]   min_val;
      inv_idx   = {IW{1'b0}};
      inv_found = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_vec[i]) begin
            inv_idx   = IW'(i);
            inv_found = 1'b1;
         end else begin
            inv_found = inv_found;
         end
      end
      min_idx = {IW{1'b0}};
      min_val = acc_count_flat[11:0];
      for (int i = 1; i < ENTRIES; i++) begin
         if (acc_count_flat[12*i +: 12] < min_val) begin
            min_val = acc_count_flat[12*i +: 12];
            min_idx = IW'(i);
         end else begin
            min_val = min_val;
         end
      end
      if (inv_found) begin
         victim_s = inv_idx;
      end else begin
         victim_s = min_idx;
      end
   end

   // Walk datapath: per-level PTE address, PTE checks and leaf PPN assembly.
   always_comb begin
      case (level_r)
         2'd2:    vpn_lvl_s = vpn_r[26:18];
         2'd1:    vpn_lvl_s = vpn_r[17:9];
         default: vpn_lvl_s = vpn_r[8:0];
      endcase
      walk_addr_s = {8'd0, a_r} + {52'd0, vpn_lvl_s, 3'd0};
      bad_pte_s   = !pte_r[0] || (!pte_r[1] && pte_r[2]);
      non_leaf_s  = !pte_r[1] && !pte_r[3];
      misalign_s  = ((level_r == 2'd2) && (|pte_r[27:10])) ||
                    ((level_r == 2'd1) && (|pte_r[18:10]));
      case (level_r)
         2'd2:    leaf_ppn_s = {pte_r[53:28], vpn_r[17:0]};
         2'd1:    leaf_ppn_s = {pte_r[53:19], vpn_r[8:0]};
         default: leaf_ppn_s = pte_r[53:10];
      endcase
   end

   // Next-state and output decode.
   always_comb begin
      state_s      = state_r;
      start_walk_s = 1'b0;
      start_dwb_s  = 1'b0;
      descend_s    = 1'b0;
      walk_fault_s = 1'b0;
      tlb_write    = {ENTRIES{1'b0}};
      tlb_clear    = 1'b0;
      tlb_d_set    = {ENTRIES{1'b0}};
      vpn_fill     = 27'd0;
      ppn_fill     = 44'd0;
      pte_fill     = 64'd0;
      pte_pa_fill  = 64'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 64'd0;
      mem_wdata    = 64'd0;
      trans_rdy    = 1'b0;
      pa_out       = 56'd0;
      load_pf      = 1'b0;
      store_pf     = 1'b0;
      ins_pf       = 1'b0;
      case (state_r)
         IDLE: begin
            if (flush) begin
               state_s = FLUSH;
            end else if (req_s && hit_s) begin
               if (!perm_ok_s) begin
                  load_pf  = read;
                  store_pf = write;
                  ins_pf   = execute;
               end else if (write && !hit_pte[7]) begin
                  state_s     = DWB;
                  start_dwb_s = 1'b1;
               end else begin
                  trans_rdy = 1'b1;
                  pa_out    = {hit_ppn, addr_va[11:0]};
               end
            end else if (req_s) begin
               state_s      = WALK_RD;
               start_walk_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         WALK_RD: begin
            mem_req  = 1'b1;
            mem_addr = walk_addr_s;
            if (mem_rdy) begin
               state_s = WALK_CHK;
            end else begin
               state_s = WALK_RD;
            end
         end
         WALK_CHK: begin
            if (bad_pte_s) begin
               walk_fault_s = 1'b1;
               state_s      = IDLE;
            end else if (non_leaf_s) begin
               if (level_r == 2'd0) begin
                  walk_fault_s = 1'b1;
                  state_s      = IDLE;
               end else begin
                  descend_s = 1'b1;
                  state_s   = WALK_RD;
               end
            end else if (misalign_s) begin
               walk_fault_s = 1'b1;
               state_s      = IDLE;
            end else begin
               state_s = FILL;
            end
         end
         FILL: begin
            tlb_write   = onehot_f(victim_s);
            vpn_fill    = vpn_r;
            ppn_fill    = leaf_ppn_s;
            pte_fill    = pte_r;
            pte_pa_fill = pte_addr_r;
            state_s     = IDLE;
         end
         DWB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dwb_addr_r;
            mem_wdata = dwb_data_r;
            if (mem_rdy) begin
               state_s = DSET;
            end else begin
               state_s = DWB;
            end
         end
         DSET: begin
            tlb_d_set = onehot_f(hit_idx_r);
            state_s   = IDLE;
         end
         FLUSH: begin
            tlb_clear = 1'b1;
            state_s   = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // A walk fault is reported only while the originating request is still held.
      if (walk_fault_s) begin
         load_pf  = rd_r & read;
         store_pf = wr_r & write;
         ins_pf   = ex_r & execute;
      end else begin
         walk_fault_s = 1'b0;
      end
   end

   // State and walk/write-back context registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         level_r    <= 2'd2;
         a_r        <= 56'd0;
         vpn_r      <= 27'd0;
         pte_r      <= 64'd0;
         pte_addr_r <= 64'd0;
         rd_r       <= 1'b0;
         wr_r       <= 1'b0;
         ex_r       <= 1'b0;
         hit_idx_r  <= {IW{1'b0}};
         dwb_addr_r <= 64'd0;
         dwb_data_r <= 64'd0;
      end else begin
         state_r <= state_s;
         if (start_walk_s) begin
            vpn_r   <= addr_va[38:12];
            level_r <= 2'd2;
            a_r     <= {satp_ppn, 12'd0};
            rd_r    <= read;
            wr_r    <= write;
            ex_r    <= execute;
         end
         if ((state_r == WALK_RD) && mem_rdy) begin
            pte_r      <= mem_rdata;
            pte_addr_r <= walk_addr_s;
         end
         if (descend_s) begin
            level_r <= level_r - 2'd1;
            a_r     <= {pte_r[53:10], 12'd0};
         end
         if (start_dwb_s) begin
            hit_idx_r  <= hit_idx_s;
            dwb_addr_r <= hit_pte_pa;
            dwb_data_r <= hit_pte | 64'h0000_0000_0000_00C0;
         end
      end
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed, table-driven bench for tlb_ctrl with a scripted
// single-port memory responder for page-table walks and A|D write-backs.
module tb_tlb_ctrl;

   localparam int ENTRIES = 8;
   localparam int IW      = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  read, write, execute;
   logic [63:0]           addr_va;
   logic [43:0]           satp_ppn;
   logic                  flush;
   logic [ENTRIES-1:0]    hit_vec, valid_vec;
   logic [12*ENTRIES-1:0] acc_count_flat;
   logic [63:0]           hit_pte, hit_pte_pa;
   logic [43:0]           hit_ppn;
   logic [ENTRIES-1:0]    tlb_write, tlb_d_set;
   logic                  tlb_clear;
   logic [26:0]           vpn_fill;
   logic [43:0]           ppn_fill;
   logic [63:0]           pte_fill, pte_pa_fill;
   logic                  mem_req, mem_we, mem_rdy;
   logic [63:0]           mem_addr, mem_wdata, mem_rdata;
   logic                  trans_rdy;
   logic [55:0]           pa_out;
   logic                  load_pf, store_pf, ins_pf;

   int n_cmp  = 0;
   int n_fail = 0;

   tlb_ctrl #(.ENTRIES(ENTRIES), .IW(IW)) dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .execute(execute),
      .addr_va(addr_va), .satp_ppn(satp_ppn), .flush(flush),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .acc_count_flat(acc_count_flat),
      .hit_pte(hit_pte), .hit_pte_pa(hit_pte_pa), .hit_ppn(hit_ppn),
      .tlb_write(tlb_write), .tlb_clear(tlb_clear), .tlb_d_set(tlb_d_set),
      .vpn_fill(vpn_fill), .ppn_fill(ppn_fill), .pte_fill(pte_fill),
      .pte_pa_fill(pte_pa_fill), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
      .mem_rdata(mem_rdata), .trans_rdy(trans_rdy), .pa_out(pa_out),
      .load_pf(load_pf), .store_pf(store_pf), .ins_pf(ins_pf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        ex;
      logic [7:0]  hv;
      logic [63:0] pte;
      logic [43:0] ppn;
      logic [63:0] va;
      logic [60:0] exp;   // {trans_rdy, load_pf, store_pf, ins_pf, mem_req, pa_out}
   } vec_t;

   typedef struct {
      logic [7:0]  valid;
      logic [95:0] acc;
      logic [7:0]  exp_wr;
   } repl_t;

   vec_t  vecs[8];
   repl_t repl[3];

   function automatic logic [60:0] mk_exp(input logic tr, input logic lp, input logic sp,
                                          input logic ip, input logic [55:0] pa);
      return {tr, lp, sp, ip, 1'b0, pa};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Serve one memory access: wait for it, check it, hold one cycle, respond.
   task automatic mem_serve(input string nm, input logic [63:0] ea, input logic ewe,
                            input logic [63:0] ewd, input logic [63:0] rd);
      int k;
      k = 0;
      #1;
      while (!mem_req && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      chk({nm, "_req"}, mem_req, 1'b1);
      chk({nm, "_addr"}, {mem_we, mem_addr}, {ewe, ea});
      if (ewe) chk({nm, "_wdata"}, mem_wdata, ewd);
      @(negedge clk); #1;
      chk({nm, "_stable"}, {mem_req, mem_addr}, {1'b1, ea});
      mem_rdy   = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_rdy   = 1'b0;
      mem_rdata = 64'd0;
      #1;
      chk({nm, "_drop"}, mem_req, 1'b0);
   endtask

   task automatic wait_fill(input string nm);
      int k;
      k = 0;
      while (tlb_write == 8'd0 && k < 10) begin
         @(negedge clk); #1;
         k++;
      end
      chk({nm, "_fill_seen"}, (tlb_write != 8'd0), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst = 1'b1; read = 1'b0; write = 1'b0; execute = 1'b0;
      addr_va = 64'd0; satp_ppn = 44'd0; flush = 1'b0;
      hit_vec = 8'd0; valid_vec = 8'd0; acc_count_flat = 96'd0;
      hit_pte = 64'd0; hit_pte_pa = 64'd0; hit_ppn = 44'd0;
      mem_rdy = 1'b0; mem_rdata = 64'd0;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h08, 64'hCF, 44'h12345, 64'h0040_1ABC,
                  mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 56'h1234_5ABC)};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h08, 64'hCF, 44'h12345, 64'h0040_1ABC,
                  mk_exp(1'b0, 1'b0, 1'b0, 1'b0, 56'h0)};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h01, 64'h09, 44'h1, 64'h0,
                  mk_exp(1'b0, 1'b1, 1'b0, 1'b0, 56'h0)};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h02, 64'h0B, 44'h1, 64'h0,
                  mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 56'h0)};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h80, 64'h03, 44'h1, 64'h0,
                  mk_exp(1'b0, 1'b0, 1'b0, 1'b1, 56'h0)};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h80, 64'h09, 44'hABCDE, 64'h123,
                  mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 56'hAB_CDE1_23)};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h10, 64'hC7, 44'h1, 64'hFFF,
                  mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 56'h1FFF)};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h04, 64'h0F, 44'hFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 56'hFF_FFFF_FFFF_FFFF)};

      // entries listed from 7 down to 0
      repl[0] = '{8'hFF, {12'd4, 12'd6, 12'd8, 12'd7, 12'd2, 12'd9, 12'd2, 12'd5}, 8'h02};
      repl[1] = '{8'hFF, {12'd1, 12'd3, 12'd3, 12'd3, 12'd3, 12'd3, 12'd3, 12'd3}, 8'h80};
      repl[2] = '{8'hEF, {12'd4, 12'd6, 12'd8, 12'd7, 12'd2, 12'd9, 12'd2, 12'd5}, 8'h10};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_strobes", {tlb_write, tlb_clear, tlb_d_set, mem_req, mem_we, trans_rdy,
                          load_pf, store_pf, ins_pf}, 128'd0);
      chk("rst_data", |{vpn_fill, ppn_fill, pte_fill, pte_pa_fill, mem_addr, mem_wdata, pa_out}, 1'b0);
      rst = 1'b0;

      // Hit-path table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         read = vecs[i].rd; write = vecs[i].wr; execute = vecs[i].ex;
         hit_vec = vecs[i].hv; hit_pte = vecs[i].pte; hit_ppn = vecs[i].ppn;
         addr_va = vecs[i].va;
         #1;
         chk($sformatf("vec%0d", i), {trans_rdy, load_pf, store_pf, ins_pf, mem_req, pa_out},
             {67'd0, vecs[i].exp});
      end
      @(negedge clk);
      read = 1'b0; write = 1'b0; execute = 1'b0; hit_vec = 8'd0;

      // Three-level miss
      @(negedge clk);
      satp_ppn = 44'h80000; addr_va = 64'h0040_1234; valid_vec = 8'h00; read = 1'b1;
      mem_serve("l2", 64'h8000_0000, 1'b0, 64'd0, 64'h2000_0401);
      mem_serve("l1", 64'h8000_1010, 1'b0, 64'd0, 64'h2000_0801);
      mem_serve("l0", 64'h8000_2008, 1'b0, 64'd0, 64'h2000_00CF);
      wait_fill("miss");
      chk("miss_write", tlb_write, 8'h01);
      chk("miss_fill", {vpn_fill, ppn_fill, pte_fill, pte_pa_fill},
          {27'h401, 44'h80000, 64'h2000_00CF, 64'h8000_2008});
      hit_vec = 8'h01; valid_vec = 8'h01; hit_pte = 64'h2000_00CF; hit_ppn = 44'h80000;
      @(negedge clk); #1;
      chk("miss_relookup", {tlb_write, trans_rdy, pa_out}, {8'h00, 1'b1, 56'h8000_0234});
      read = 1'b0; hit_vec = 8'h00;

      // Gigapage leaf at level 2
      @(negedge clk);
      read = 1'b1;
      mem_serve("giga", 64'h8000_0000, 1'b0, 64'd0, 64'h2000_00CF);
      wait_fill("giga");
      chk("giga_write", tlb_write, 8'h02);
      chk("giga_ppn", ppn_fill, 44'h80401);
      read = 1'b0;

      // Misaligned gigapage
      @(negedge clk);
      read = 1'b1;
      mem_serve("misal", 64'h8000_0000, 1'b0, 64'd0, 64'h2000_04CF);
      chk("misal_pf", {load_pf, store_pf, ins_pf}, 3'b100);
      read = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         seen = seen | (|tlb_write) | load_pf;
      end
      chk("misal_nofill", seen, 1'b0);

      // Invalid root PTE on an execute request
      @(negedge clk);
      execute = 1'b1;
      mem_serve("inval", 64'h8000_0000, 1'b0, 64'd0, 64'h0);
      chk("inval_pf", {load_pf, store_pf, ins_pf, tlb_write}, {3'b001, 8'h00});
      execute = 1'b0;

      // Replacement
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         valid_vec = repl[c].valid; acc_count_flat = repl[c].acc; read = 1'b1;
         mem_serve($sformatf("repl%0d", c), 64'h8000_0000, 1'b0, 64'd0, 64'h2000_00CF);
         wait_fill($sformatf("repl%0d", c));
         chk($sformatf("repl%0d_victim", c), tlb_write, repl[c].exp_wr);
         read = 1'b0;
      end

      // Dirty-bit write-back
      @(negedge clk);
      write = 1'b1; hit_vec = 8'h08; hit_pte = 64'h47; hit_pte_pa = 64'h8000_1008;
      #1;
      chk("dwb_hold", {trans_rdy, store_pf}, 2'b00);
      mem_serve("dwb", 64'h8000_1008, 1'b1, 64'hC7, 64'h0);
      chk("dset", tlb_d_set, 8'h08);
      hit_pte = 64'hC7;
      @(negedge clk); #1;
      chk("dset_done", {tlb_d_set, trans_rdy}, {8'h00, 1'b1});
      write = 1'b0; hit_vec = 8'h00;

      // Flush, with priority over a hitting request
      @(negedge clk);
      flush = 1'b1; read = 1'b1; hit_vec = 8'h01; hit_pte = 64'hCF;
      #1;
      chk("flush_prio", {trans_rdy, tlb_clear}, 2'b00);
      @(negedge clk); #1;
      chk("flush_clear", tlb_clear, 1'b1);
      flush = 1'b0; read = 1'b0;
      @(negedge clk); #1;
      chk("flush_once", tlb_clear, 1'b0);

      // Reset mid-walk
      @(negedge clk);
      hit_vec = 8'h00; read = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk); #1;
         seen = mem_req;
      end
      chk("rstwalk_req", seen, 1'b1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rstwalk_idle", {mem_req, trans_rdy}, 2'b00);
      rst = 1'b0; read = 1'b0;
      @(negedge clk);
      read = 1'b1; hit_vec = 8'h01; hit_pte = 64'hCF; hit_ppn = 44'h55; addr_va = 64'h0;
      #1;
      chk("rstwalk_hit", {trans_rdy, mem_req, pa_out}, {1'b1, 1'b0, 56'h55000});
      @(negedge clk);
      read = 1'b0; hit_vec = 8'h00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencing controller for the Sv39 TLB array built from TLB entries in the CPU bus interface unit. On a translation request it qualifies the array's hit vector and checks permissions. On a miss it runs the three-level page-table walk over a single memory port, chooses a victim entry and fills it. On the first store to a clean page it writes the updated PTE (A|D set) back to memory, then pulses that entry's D-set strobe. It also sequences SFENCE-style flushes.

## Interface
- ENTRIES, 8: number of TLB entries (power of two, 2..32)
- IW, 3: log2(ENTRIES)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- read / write / execute  in  1 each  request type, held until trans_rdy or a fault; at most one set
- addr_va  in  64  virtual address; bits 38:12 form the VPN
- satp_ppn  in  44  root page-table PPN
- flush  in  1  invalidate all entries
- hit_vec  in  ENTRIES  per-entry TLB_hit
- valid_vec  in  ENTRIES  per-entry valid
- acc_count_flat  in  12*ENTRIES  entry i occupies bits [12i+11:12i]
- hit_pte  in  64  PTE_out of the hitting entry (external mux)
- hit_pte_pa  in  64  PTE_pa_out of the hitting entry
- hit_ppn  in  44  PPN_out of the hitting entry
- tlb_write  out  ENTRIES  one-hot fill strobe
- tlb_clear  out  1  flush strobe, all entries
- tlb_d_set  out  ENTRIES  one-hot D-set strobe
- vpn_fill / ppn_fill / pte_fill / pte_pa_fill  out  27/44/64/64  fill data
- mem_req  out  1  memory access request
- mem_we  out  1  write access
- mem_addr  out  64  memory address
- mem_wdata  out  64  write data
- mem_rdy  in  1  access done, rdata valid
- mem_rdata  in  64  read data
- trans_rdy  out  1  translation valid this cycle
- pa_out  out  56  {hit_ppn, addr_va[11:0]}
- load_pf / store_pf / ins_pf  out  1 each  page-fault pulse, one cycle

## Operation
- States: IDLE, WALK_RD, WALK_CHK, FILL, DWB, DSET, FLUSH.
- IDLE, request with |hit_vec:
  - Permission fault: read needs hit_pte R, write needs W, execute needs X. On failure pulse the matching *_pf.
  - A write to a page with hit_pte D=0 (and no permission fault) goes to DWB.
  - Otherwise trans_rdy=1, combinationally, in the same cycle.
- IDLE, request with a miss: latch the VA, set level=2, a=satp_ppn<<12, go to WALK_RD.
- WALK_RD: hold mem_req=1, mem_we=0, mem_addr = a + VPN[level]*8, where VPN[2]=va[38:30], VPN[1]=va[29:21], VPN[0]=va[20:12]. On mem_rdy, latch the PTE and its address, go to WALK_CHK.
- WALK_CHK, checks in order:
  - V=0, or R=0 with W=1: fault.
  - R=0 and X=0: non-leaf. If level==0, fault. Otherwise level--, a = PTE[53:10]<<12, back to WALK_RD.
  - Leaf with level>0 and nonzero low PPN bits (level 2: PTE[27:10]; level 1: PTE[18:10]): misaligned superpage, fault.
  - Leaf otherwise: go to FILL.
- Any walk fault pulses the *_pf matching the request type and returns to IDLE. No fill occurs.
- FILL: for one cycle drive tlb_write on the victim, with:
  - vpn_fill = va[38:12]
  - pte_fill = latched PTE
  - pte_pa_fill = PTE address
  - ppn_fill = PTE[53:10], with superpage low bits replaced from the VA (level 2: bits 17:0 ← va[29:12]; level 1: bits 8:0 ← va[20:12])
- After FILL return to IDLE. The held request then hits and runs the normal hit path, including permission and D checks.
- Victim selection:
  - The lowest-index entry with valid=0.
  - If all entries are valid, the entry with minimum acc_count; ties go to the lowest index.
  - The choice is computed from inputs sampled in FILL.
- DWB: mem_req=1, mem_we=1, mem_addr=hit_pte_pa, mem_wdata = hit_pte | 0xC0 (A and D). On mem_rdy go to DSET.
- DSET: one-cycle tlb_d_set on the hitting entry (the hit index is latched on entry to DWB), then IDLE.
- flush is sampled only in IDLE and has priority over a request. FLUSH asserts tlb_clear for one cycle, then returns to IDLE.
- A flush arriving mid-walk or mid-DWB is ignored until the controller is back in IDLE; the requester must hold it.

## Timing
- Reset: state=IDLE, level=2. All strobes, mem_req, mem_we, trans_rdy and *_pf are 0; every data output is 0.
- Hit latency: 0 cycles (combinational trans_rdy).
- Miss latency: per level, mem latency + 2 cycles (WALK_RD issue, WALK_CHK). Add 1 for FILL and 1 for the IDLE re-lookup.
- mem_req and mem_addr stay stable from assertion until the mem_rdy cycle. mem_req drops the cycle after mem_rdy.
- rst mid-walk or mid-DWB returns to IDLE the next edge; any outstanding memory response is ignored.
- A request withdrawn mid-walk still completes the fill; no fault or trans_rdy is generated.

## Test plan
- Hit: entry 3 valid and hitting, hit_pte=0xCF (read request) -> trans_rdy the same cycle, pa_out={hit_ppn, va[11:0]}, no mem_req.
- Three-level miss: satp_ppn=0x80000, va=0x0040_1234, leaf at level 0 with PTE=0x2000_00CF -> reads at 0x8000_0000, then two child-table addresses; tlb_write on entry 0 (all invalid); ppn_fill=0x80000; trans_rdy after the re-lookup.
- Gigapage: leaf at level 2, PTE[27:10]=0 -> ppn_fill[17:0]=va[29:12]. Same walk with PTE[10]=1 -> misaligned, load_pf pulse, no tlb_write.
- Replacement: all 8 entries valid, acc_counts {5,2,9,2,…} -> victim is entry 1.
- D update: write hit with hit_pte=0x47, hit_pte_pa=0x8000_1008 -> mem write of 0xC7 to 0x8000_1008, then a one-cycle tlb_d_set on the hit entry, then trans_rdy.
- Flush and reset: flush in IDLE -> tlb_clear for exactly 1 cycle. rst asserted while mem_req is high -> mem_req=0 and IDLE after one edge.
